// File: rtl/divisor_restaurador.sv
// divisor_restaurador: restoring divider, one quotient bit per clock; LARGURA+2 cycles per operation.
// Define DIVISOR_SINAL_EN to add the com_sinal port for signed (truncating) division.
module divisor_restaurador #(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
`ifdef DIVISOR_SINAL_EN
    input  logic               com_sinal,
`endif
    input  logic [LARGURA-1:0] dividendo,
    input  logic [LARGURA-1:0] divisor,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] quociente,
    output logic [LARGURA-1:0] resto,
    output logic               div_zero
);
    localparam int CW = $clog2(LARGURA + 1);
    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;
    estado_t estado;
    logic [LARGURA:0] r;
    logic [LARGURA-1:0] q, d, a_mag, b_mag;
    logic [CW-1:0] cont;
    logic zero, neg_q, neg_r, sinal_q, sinal_r;
    logic [LARGURA+1:0] desl, t;
    always_comb begin
        desl = {r, q[LARGURA-1]};
        t = desl - {2'b0, d};
`ifdef DIVISOR_SINAL_EN
        a_mag = (com_sinal && dividendo[LARGURA-1]) ? -dividendo : dividendo;
        b_mag = (com_sinal && divisor[LARGURA-1]) ? -divisor : divisor;
        sinal_q = com_sinal && (dividendo[LARGURA-1] ^ divisor[LARGURA-1]);
        sinal_r = com_sinal && dividendo[LARGURA-1];
`else
        a_mag = dividendo;
        b_mag = divisor;
        sinal_q = 1'b0;
        sinal_r = 1'b0;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
            r <= '0;
            q <= '0;
            d <= '0;
            cont <= '0;
            zero <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ocupado <= 1'b0;
            pronto <= 1'b0;
            quociente <= '0;
            resto <= '0;
            div_zero <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: if (inicio) begin
                    zero <= divisor == '0;
                    q <= (divisor == '0) ? dividendo : a_mag;
                    d <= b_mag;
                    r <= '0;
                    neg_q <= sinal_q;
                    neg_r <= sinal_r;
                    cont <= CW'(LARGURA);
                    ocupado <= 1'b1;
                    estado <= (divisor == '0) ? FIM : CALCULA;
                end
                CALCULA: begin
                    // borrow out of the trial subtraction means the shifted remainder is kept
                    r <= t[LARGURA+1] ? desl[LARGURA:0] : t[LARGURA:0];
                    q <= {q[LARGURA-2:0], ~t[LARGURA+1]};
                    cont <= cont - 1'b1;
                    if (cont == CW'(1)) estado <= FIM;
                end
                FIM: begin
                    quociente <= zero ? '1 : (neg_q ? -q : q);
                    resto <= zero ? q : (neg_r ? -r[LARGURA-1:0] : r[LARGURA-1:0]);
                    div_zero <= zero;
                    pronto <= 1'b1;
                    ocupado <= 1'b0;
                    estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_restaurador.sv
// tb_divisor_restaurador: directed and random checks of divisor_restaurador with a result scoreboard.
module tb_divisor_restaurador;
    localparam int W = 32;
    logic clk = 1'b0, rst_n = 1'b0, inicio = 1'b0;
    logic [W-1:0] dividendo = '0, divisor = '0;
`ifdef DIVISOR_SINAL_EN
    logic com_sinal = 1'b0;
`endif
    logic ocupado, pronto, div_zero;
    logic [W-1:0] quociente, resto;
    typedef struct packed {logic [W-1:0] q; logic [W-1:0] r; logic dz;} res_t;
    res_t fila[$];
    res_t e;
    int checks = 0, passed = 0, failed = 0;

    always #5 clk = ~clk;

    divisor_restaurador #(.LARGURA(W)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio),
`ifdef DIVISOR_SINAL_EN
        .com_sinal(com_sinal),
`endif
        .dividendo(dividendo), .divisor(divisor),
        .ocupado(ocupado), .pronto(pronto),
        .quociente(quociente), .resto(resto), .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && pronto) begin
        if (fila.size() == 0) check("pronto sem operacao", W'(pronto), '0);
        else begin
            e = fila.pop_front();
            check("quociente", quociente, e.q);
            check("resto", resto, e.r);
            check("div_zero", W'(div_zero), W'(e.dz));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int lat, input bit intruso);
        logic [W-1:0] prev;
        int n;
        @(negedge clk);
        for (int i = 0; i < 100 && ocupado; i++) @(negedge clk);
        prev = quociente;
        inicio = 1'b1;
        dividendo = a;
        divisor = b;
`ifdef DIVISOR_SINAL_EN
        com_sinal = sgn;
`endif
        fila.push_back('{eq, er, edz});
        @(posedge clk); #1;
        inicio = 1'b0;
        check("ocupado apos aceite", W'(ocupado), W'(1));
        check("quociente mantido", quociente, prev);
        n = 0;
        while (!pronto && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (intruso && n == 5) begin
                inicio = 1'b1;
                dividendo = 9;
                divisor = 3;
            end else inicio = 1'b0;
        end
        inicio = 1'b0;
        check("latencia", W'(n), W'(lat));
        check("ocupado em pronto", W'(ocupado), '0);
        @(posedge clk); #1;
        check("pulso unico", W'(pronto), '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        repeat (2) @(negedge clk);
        check("reset ocupado", W'(ocupado), '0);
        check("reset pronto", W'(pronto), '0);
        check("reset quociente", quociente, '0);
        check("reset resto", resto, '0);
        check("reset div_zero", W'(div_zero), '0);
        rst_n = 1'b1;
        run_op(100, 7, 1'b0, 14, 2, 1'b0, 33, 1'b0);
        run_op(32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, 33, 1'b0);
        run_op(5, 32'hFFFF_FFFF, 1'b0, 0, 5, 1'b0, 33, 1'b0);
        run_op(32'hFFFF_FFFE, 32'h8000_0001, 1'b0, 1, 32'h7FFF_FFFD, 1'b0, 33, 1'b0);
        run_op(1234, 0, 1'b0, 32'hFFFF_FFFF, 1234, 1'b1, 1, 1'b0);
        run_op(100, 7, 1'b0, 14, 2, 1'b0, 33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 1;
            run_op(a, b, 1'b0, a / b, a % b, 1'b0, 33, 1'b0);
        end
        @(negedge clk);
        inicio = 1'b1;
        dividendo = 100;
        divisor = 7;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst ocupado", W'(ocupado), '0);
        check("rst pronto", W'(pronto), '0);
        check("rst quociente", quociente, '0);
        check("rst resto", resto, '0);
        check("rst div_zero", W'(div_zero), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(50, 5, 1'b0, 10, 0, 1'b0, 33, 1'b0);
`ifdef DIVISOR_SINAL_EN
        run_op(-32'sd7, 2, 1'b1, -32'sd3, -32'sd1, 1'b0, 33, 1'b0);
        run_op(7, -32'sd2, 1'b1, -32'sd3, 1, 1'b0, 33, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0, 33, 1'b0);
`endif
        @(negedge clk);
        check("fila vazia", W'(fila.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
